// File: rtl/dpram_fifo_ctrl_pkg.sv
// Shared sizing constants and small types for the dual-port-RAM FIFO controller.
package dpram_fifo_ctrl_pkg;

    localparam int DW_DEF    = 16;
    localparam int AW_DEF    = 8;
    localparam int RAM_DEPTH = 1 << AW_DEF;
    localparam int BUF_DEPTH = 2;

    typedef enum logic [1:0] {
        OP_NONE    = 2'b00,
        OP_POP     = 2'b01,
        OP_CAPTURE = 2'b10,
        OP_BOTH    = 2'b11
    } buf_op_e;

endpackage

// File: rtl/dpram_fifo_ctrl_if.sv
// Bundle of the upstream/downstream streams, flush and both RAM ports.
interface dpram_fifo_ctrl_if
    import dpram_fifo_ctrl_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
);
    logic          flush;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_ready;
    logic [AW+1:0] count;
    logic          ram_ena;
    logic          ram_wea;
    logic [AW-1:0] ram_addra;
    logic [DW-1:0] ram_dia;
    logic          ram_enb;
    logic          ram_web;
    logic [AW-1:0] ram_addrb;
    logic [DW-1:0] ram_dib;
    logic [DW-1:0] ram_dob;

    // The FIFO controller side.
    modport slave (
        input  flush, in_valid, in_data, out_ready, ram_dob,
        output in_ready, out_valid, out_data, count,
        output ram_ena, ram_wea, ram_addra, ram_dia,
        output ram_enb, ram_web, ram_addrb, ram_dib
    );

    // The producer / consumer / RAM side.
    modport master (
        output flush, in_valid, in_data, out_ready, ram_dob,
        input  in_ready, out_valid, out_data, count,
        input  ram_ena, ram_wea, ram_addra, ram_dia,
        input  ram_enb, ram_web, ram_addrb, ram_dib
    );

endinterface

// File: rtl/dpram_fifo_obuf.sv
// Two-entry show-ahead output buffer that hides the RAM's registered read latency.
module dpram_fifo_obuf
    import dpram_fifo_ctrl_pkg::*;
#(
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          capture,
    input  logic [DW-1:0] din,
    input  logic          pop,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    output logic [1:0]    buf_cnt
);

    logic [DW-1:0] head;
    logic [DW-1:0] tail;
    logic [1:0]    cnt;
    buf_op_e       op;

    assign out_valid = (cnt != 2'd0);
    assign out_data  = head;
    assign buf_cnt   = cnt;

    always_comb begin
        op = OP_NONE;
        if (capture && pop && out_valid) begin
            op = OP_BOTH;
        end else if (capture) begin
            op = OP_CAPTURE;
        end else if (pop && out_valid) begin
            op = OP_POP;
        end
    end

    // head is always the oldest word, so out_data stays put while stalled.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            head <= '0;
            tail <= '0;
            cnt  <= 2'd0;
        end else begin
            case (op)
                OP_CAPTURE: begin
                    if (cnt == 2'd0) head <= din;
                    else             tail <= din;
                    cnt <= cnt + 2'd1;
                end
                OP_POP: begin
                    head <= tail;
                    cnt  <= cnt - 2'd1;
                end
                OP_BOTH: begin
                    if (cnt == 2'd1) begin
                        head <= din;
                    end else begin
                        head <= tail;
                        tail <= din;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/dpram_fifo_ctrl.sv
// FIFO controller: port A writes, port B reads ahead into a 2-entry output buffer.
module dpram_fifo_ctrl
    import dpram_fifo_ctrl_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    dpram_fifo_ctrl_if.slave   bus
);

    localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   ram_cnt;
    logic          rd_inflight;
    logic [1:0]    buf_cnt;
    logic          clr;
    logic          ready;
    logic          push;
    logic          pop;
    logic          issue;
    logic [2:0]    pending;
    logic          obuf_valid;
    logic [DW-1:0] obuf_data;

    assign clr   = !rst_n || bus.flush;
    assign ready = (ram_cnt != DEPTH);
    assign push  = bus.in_valid && ready && !clr;
    assign pop   = obuf_valid && bus.out_ready;

    // Reads issue only while the buffer can still take the word once it lands.
    assign pending = {1'b0, buf_cnt} + {2'b00, rd_inflight} - {2'b00, pop};
    assign issue   = !clr && (ram_cnt != '0) && (pending < 3'd2);

    always_ff @(posedge clk) begin
        if (clr) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            ram_cnt     <= '0;
            rd_inflight <= 1'b0;
        end else begin
            if (push)  wr_ptr <= wr_ptr + 1'b1;
            if (issue) rd_ptr <= rd_ptr + 1'b1;
            ram_cnt     <= ram_cnt + (AW+1)'(push) - (AW+1)'(issue);
            rd_inflight <= issue;
        end
    end

    dpram_fifo_obuf #(.DW(DW)) u_obuf (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (bus.flush),
        .capture   (rd_inflight),
        .din       (bus.ram_dob),
        .pop       (bus.out_ready),
        .out_valid (obuf_valid),
        .out_data  (obuf_data),
        .buf_cnt   (buf_cnt)
    );

    assign bus.in_ready  = ready;
    assign bus.out_valid = obuf_valid;
    assign bus.out_data  = obuf_data;
    assign bus.count     = (AW+2)'(ram_cnt) + (AW+2)'(rd_inflight) + (AW+2)'(buf_cnt);

    assign bus.ram_ena   = push;
    assign bus.ram_wea   = push;
    assign bus.ram_addra = wr_ptr;
    assign bus.ram_dia   = bus.in_data;
    assign bus.ram_enb   = issue;
    assign bus.ram_web   = 1'b0;
    assign bus.ram_addrb = rd_ptr;
    assign bus.ram_dib   = '0;

endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
// Scoreboard bench for dpram_fifo_ctrl with a behavioural 256x16 dual-port RAM.
module tb_dpram_fifo_ctrl;
    import dpram_fifo_ctrl_pkg::*;

    localparam int AW = 8;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    int checks = 0;
    int errors = 0;
    int pushes = 0;
    logic [DW-1:0] exp_q[$];

    dpram_fifo_ctrl_if #(.AW(AW), .DW(DW)) bus();

    dpram_fifo_ctrl #(.AW(AW), .DW(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    always @(posedge clk) begin
        if (bus.ram_ena && bus.ram_wea) mem[bus.ram_addra] <= bus.ram_dia;
        if (bus.ram_enb && !bus.ram_web) bus.ram_dob <= mem[bus.ram_addrb];
    end

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Inputs change 1 time unit after the edge; acceptance is decided from in_ready of this cycle.
    task automatic apply_stimulus(input logic v, input logic [DW-1:0] d, input logic ordy, input logic fl);
        @(posedge clk);
        #1;
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.out_ready = ordy;
        bus.flush     = fl;
        if (fl) begin
            exp_q.delete();
        end else if (v && bus.in_ready) begin
            exp_q.push_back(d);
            pushes++;
        end
    endtask

    task automatic wait_drain(input int budget, output int used);
        used = 0;
        while (exp_q.size() != 0 && used < budget) begin
            apply_stimulus(1'b0, '0, 1'b1, 1'b0);
            used++;
        end
        check_output("drain_done", 32'(exp_q.size() == 0), 32'd1);
    endtask

    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data  = '0;

    // Monitor: every handshake seen mid-cycle is the pop taken at the next edge.
    always @(negedge clk) begin
        if (!rst_n || bus.flush) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check_output("stall_valid", 32'(bus.out_valid), 32'd1);
                check_output("stall_data", 32'(bus.out_data), 32'(prev_data));
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    check_output("unexpected_out", 32'(bus.out_valid), 32'd0);
                end else begin
                    check_output("out_data", 32'(bus.out_data), 32'(exp_q.pop_front()));
                end
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_data  = bus.out_data;
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int used;
        bus.in_valid  = 1'b1;
        bus.in_data   = 16'h5555;
        bus.out_ready = 1'b0;
        bus.flush     = 1'b0;
        rst_n         = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check_output("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check_output("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check_output("rst_out_data", 32'(bus.out_data), 32'd0);
        check_output("rst_count", 32'(bus.count), 32'd0);
        check_output("rst_ram_ena", 32'(bus.ram_ena), 32'd0);
        check_output("rst_ram_enb", 32'(bus.ram_enb), 32'd0);
        rst_n        = 1'b1;
        bus.in_valid = 1'b0;

        $display("[TB] single word latency");
        apply_stimulus(1'b1, 16'hA5A5, 1'b1, 1'b0);
        apply_stimulus(1'b0, '0, 1'b1, 1'b0);
        check_output("lat_e0_valid", 32'(bus.out_valid), 32'd0);
        check_output("lat_e0_count", 32'(bus.count), 32'd1);
        apply_stimulus(1'b0, '0, 1'b1, 1'b0);
        check_output("lat_e1_valid", 32'(bus.out_valid), 32'd0);
        apply_stimulus(1'b0, '0, 1'b1, 1'b0);
        check_output("lat_e2_valid", 32'(bus.out_valid), 32'd1);
        check_output("lat_e2_data", 32'(bus.out_data), 32'hA5A5);
        apply_stimulus(1'b0, '0, 1'b1, 1'b0);
        check_output("lat_e3_count", 32'(bus.count), 32'd0);
        check_output("lat_e3_valid", 32'(bus.out_valid), 32'd0);

        $display("[TB] streaming 1024 words");
        for (int i = 0; i < 1024; i++) apply_stimulus(1'b1, 16'(i), 1'b1, 1'b0);
        wait_drain(20, used);
        check_output("stream_drain_fast", 32'(used <= 5), 32'd1);

        $display("[TB] fill with consumer stalled");
        pushes = 0;
        for (int i = 0; i < 260; i++) apply_stimulus(1'b1, 16'(i), 1'b0, 1'b0);
        check_output("fill_accepted", 32'(pushes), 32'd258);
        apply_stimulus(1'b0, '0, 1'b0, 1'b0);
        apply_stimulus(1'b0, '0, 1'b0, 1'b0);
        check_output("fill_count", 32'(bus.count), 32'd258);
        check_output("fill_in_ready", 32'(bus.in_ready), 32'd0);
        check_output("fill_head", 32'(bus.out_data), 32'd0);
        wait_drain(400, used);
        apply_stimulus(1'b0, '0, 1'b1, 1'b0);
        apply_stimulus(1'b0, '0, 1'b1, 1'b0);
        check_output("drain_count", 32'(bus.count), 32'd0);
        check_output("drain_in_ready", 32'(bus.in_ready), 32'd1);

        $display("[TB] random backpressure");
        for (int i = 0; i < 300; i++) apply_stimulus(1'b1, 16'(16'h8000 + i), 1'($urandom_range(0, 1)), 1'b0);
        wait_drain(600, used);

        $display("[TB] flush mid-stream");
        for (int i = 0; i < 4; i++) apply_stimulus(1'b1, 16'(16'h1110 + i), 1'b1, 1'b0);
        apply_stimulus(1'b1, 16'hDEAD, 1'b1, 1'b1);
        apply_stimulus(1'b0, '0, 1'b1, 1'b0);
        check_output("flush_count", 32'(bus.count), 32'd0);
        check_output("flush_valid", 32'(bus.out_valid), 32'd0);
        apply_stimulus(1'b1, 16'h1234, 1'b1, 1'b0);
        wait_drain(10, used);
        repeat (3) apply_stimulus(1'b0, '0, 1'b1, 1'b0);
        check_output("post_flush_count", 32'(bus.count), 32'd0);
        check_output("post_flush_valid", 32'(bus.out_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dpram_fifo_ctrl.md
# dpram_fifo_ctrl

Single-clock FIFO controller that drives the two ports of the 256×16 dual-port RAM: port A as the write port, port B as the read port. Upstream producers push words through a valid/ready interface; the block generates RAM addresses, tracks occupancy, hides the RAM's one-cycle registered read latency with a 2-entry output buffer, and presents a show-ahead valid/ready stream downstream.

## Interface
- AW, 8: RAM address width; RAM depth is 2^AW.
- DW, 16: data width.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- flush  in  1  synchronous clear of all contents; same effect as reset except the RAM is untouched.
- in_valid  in  1  producer has a word.
- in_data  in  DW  word to push.
- in_ready  out  1  space available; a push occurs when in_valid && in_ready.
- out_valid  out  1  head word valid.
- out_data  out  DW  head word.
- out_ready  in  1  consumer accepts; a pop occurs when out_valid && out_ready.
- count  out  AW+2  total words held (RAM + in-flight read + output buffer).
- ram_ena, ram_wea  out  1  port A enable / write enable.
- ram_addra  out  AW  port A address.
- ram_dia  out  DW  port A write data.
- ram_enb, ram_web  out  1  port B enable / write enable; ram_web is constant 0.
- ram_addrb  out  AW  port B address.
- ram_dib  out  DW  constant 0.
- ram_dob  in  DW  port B registered read data.

## Operation
- Reset (rst_n=0) or flush=1 at a rising edge: wr_ptr=rd_ptr=0, ram_cnt=0, rd_inflight=0, buffer empty. Outputs after reset: in_ready=1, out_valid=0, out_data=0, count=0, all RAM enables 0, addresses 0.
- Write: ram_ena=ram_wea=(in_valid && in_ready), ram_addra=wr_ptr, ram_dia=in_data (combinational). On push, wr_ptr increments mod 2^AW.
- in_ready = (ram_cnt != 2^AW); registered-state only, never depends on out_ready or the current pop.
- Read issue: ram_enb=1, ram_addrb=rd_ptr when ram_cnt>0 and (buf_cnt + rd_inflight − pop_this_cycle) < 2. On issue, rd_ptr increments mod 2^AW, ram_cnt decrements, rd_inflight set for the next cycle.
- ram_cnt next = ram_cnt + push − issue (simultaneous push and issue leaves it unchanged).
- Capture: when rd_inflight=1, ram_dob is written into the 2-entry output buffer (FIFO order) at that edge.
- out_valid = buf_cnt>0; out_data = oldest buffer entry (registered; held stable while out_valid && !out_ready).
- A word written at edge E is never read at edge E: issue only uses ram_cnt from before the edge, so port A/B same-address collisions are impossible.
- count = ram_cnt + rd_inflight + buf_cnt; maximum 2^AW + 2.
- Pop on empty and push on full cannot occur (gated by handshakes).

## Timing
- Write latency: push at edge E0 → word in RAM after E0.
- First-word latency into empty FIFO: push at E0, read issued at E1, captured at E2, out_valid=1 in the cycle after E2 (3 cycles).
- Sustained throughput: 1 push and 1 pop per cycle with out_ready held 1.
- Backpressure: with out_ready=0, at most 2 words are buffered plus ≤1 in flight; the buffer never overflows because issue accounts for rd_inflight.
- Full: after 2^AW words resident in RAM, in_ready=0 from the next cycle; a pop frees RAM space only once a new read is issued.
- Pointer wrap: 255→0 with AW=8, no gap or duplicate.
- Reset/flush mid-transfer: an in-flight read is discarded (ram_dob ignored in the next cycle); flush takes priority over a same-cycle push/pop.

## Structure
- Shared package: DW/AW defaults, RAM depth constant, buffer depth constant (2).
- One natural sub-module: dpram_fifo_obuf (2-entry output buffer with capture/pop and buf_cnt).

## Test plan
- Reset: hold rst_n=0 two cycles with in_valid=1 → in_ready=1, out_valid=0, count=0, ram_ena=ram_enb=0.
- Single word: push 0xA5A5 into empty FIFO with out_ready=1 → out_valid=1 exactly 3 cycles later with out_data=0xA5A5, count returns 0.
- Streaming: push 0x0000..0x03FF back-to-back with out_ready=1 → same sequence out, in order, 1 word/cycle after initial latency, pointers wrap 255→0 cleanly.
- Fill: out_ready=0, push 0..259 → 258 accepted (256 RAM + 2 buffer), in_ready=0, count=258; then drain → values 0..257 in order.
- Backpressure toggle: random out_ready with continuous pushes → no loss/duplication, out_data stable while stalled.
- Flush mid-stream: flush asserted with a read in flight and push pending → next cycle count=0, out_valid=0; subsequent push 0x1234 emerges alone.
